// File: rtl/mod_pkg.sv
// -----------------------------------------------------------------------------
// mod_pkg
//   Shared types, constants and symbol-mapping helpers for the symbol-driven
//   NCO modulator (symbol_nco_modulator and nco_phase_acc).
//   Contents:
//     state_t      FSM state enum {IDLE, RUN}
//     MOD_FSK/PSK  modulation select encodings
//     MODE_1BIT/2BIT symbol width encodings
//     sym_eff      effective symbol value for the captured mode
//     map_fword    symbol -> frequency word (32-bit, caller truncates)
//     map_poff     symbol -> phase quadrant (units of 90 degrees)
// -----------------------------------------------------------------------------
package mod_pkg;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   localparam logic MOD_FSK   = 1'b0;
   localparam logic MOD_PSK   = 1'b1;

   localparam logic MODE_1BIT = 1'b0;
   localparam logic MODE_2BIT = 1'b1;

   // In 1-bit mode the upper symbol bit is ignored.
   function automatic logic [1:0] sym_eff(input logic [1:0] sym, input logic mode);
      return (mode == MODE_2BIT) ? sym : {1'b0, sym[0]};
   endfunction

   // Frequency word: fixed carrier for PSK, base + s*step for FSK.
   function automatic logic [31:0] map_fword(input logic [1:0]  s,
                                             input logic        sel,
                                             input logic [31:0] carrier,
                                             input logic [31:0] base,
                                             input logic [31:0] step);
      return (sel == MOD_PSK) ? carrier : base + ({30'd0, s} * step);
   endfunction

   // Phase offset expressed as a quadrant index; the caller places it in the
   // top two bits of the phase word. BPSK uses only quadrants 0 and 2.
   function automatic logic [1:0] map_poff(input logic [1:0] s, input logic mode);
      return (mode == MODE_2BIT) ? s : {s[0], 1'b0};
   endfunction

endpackage

// File: rtl/nco_phase_acc.sv
// -----------------------------------------------------------------------------
// nco_phase_acc
//   NCO phase accumulator: adder plus register, wrapping modulo 2^PHASE_W.
//   Ports:
//     clk    in   1        sample clock
//     rst    in   1        synchronous active-high reset, clears acc
//     clr    in   1        synchronous clear (has priority over en)
//     en     in   1        add fword this clock
//     fword  in   PHASE_W  frequency word
//     acc    out  PHASE_W  current accumulator value
// -----------------------------------------------------------------------------
module nco_phase_acc #(
   parameter int unsigned PHASE_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               en,
   input  logic [PHASE_W-1:0] fword,
   output logic [PHASE_W-1:0] acc
);

   logic [PHASE_W-1:0] acc_d;
   logic [PHASE_W-1:0] acc_q;

   always_comb begin
      acc_d = acc_q;
      if (clr) begin
         acc_d = '0;
      end else if (en) begin
         acc_d = acc_q + fword;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/symbol_nco_modulator.sv
// -----------------------------------------------------------------------------
// symbol_nco_modulator
//   Samples a 1/2-bit symbol once per SPS clocks, maps it to an FSK frequency
//   word or a PSK phase offset and drives an NCO, emitting one phase sample
//   per clock.
//   Ports:
//     clk          in   1        sample clock
//     rst          in   1        synchronous active-high reset
//     enable       in   1        run modulator; low returns to IDLE
//     mode         in   1        0: 1-bit symbols, 1: 2-bit symbols
//     mod_sel      in   1        0: FSK, 1: PSK
//     sym_in       in   2        symbol word
//     sym_strobe   out  1        pulse after each symbol capture
//     phase_out    out  PHASE_W  registered phase (accumulator + PSK offset)
//     phase_valid  out  1        phase_out valid
//   Configuration:
//     DIFF_ENC_EN  when defined, PSK offsets come from a running differential
//                  sum of the symbols instead of the symbols themselves.
// -----------------------------------------------------------------------------
module symbol_nco_modulator
   import mod_pkg::*;
#(
   parameter int unsigned        PHASE_W    = 16,
   parameter int unsigned        SPS        = 4,
   parameter logic [PHASE_W-1:0] FW_CARRIER = PHASE_W'(16'h1000),
   parameter logic [PHASE_W-1:0] FW_BASE    = PHASE_W'(16'h0800),
   parameter logic [PHASE_W-1:0] FW_STEP    = PHASE_W'(16'h0200)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic               mode,
   input  logic               mod_sel,
   input  logic [1:0]         sym_in,
   output logic               sym_strobe,
   output logic [PHASE_W-1:0] phase_out,
   output logic               phase_valid
);

   localparam int unsigned    CNT_W    = (SPS > 1) ? $clog2(SPS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPS - 1);

   state_t             state_d, state_q;
   logic [CNT_W-1:0]   cnt_d, cnt_q;
   logic [1:0]         sym_d, sym_q;
   logic               mode_d, mode_q;
   logic               sel_d, sel_q;
   logic               strobe_d, strobe_q;
   logic               valid_d, valid_q;
   logic [PHASE_W-1:0] phase_d, phase_q;

   logic               capture;
   logic               acc_clr;
   logic               acc_en;
   logic [PHASE_W-1:0] acc;
   logic [1:0]         s_cur;
   logic [1:0]         quad;
   logic [PHASE_W-1:0] fword;
   logic [PHASE_W-1:0] poff;

`ifdef DIFF_ENC_EN
   logic [1:0] diff_d, diff_q;
   logic [1:0] s_new;
   logic [1:0] diff_sum;
`endif

   // Mapping of the currently held symbol.
   always_comb begin
      s_cur = sym_eff(sym_q, mode_q);
      fword = PHASE_W'(map_fword(s_cur, sel_q, 32'(FW_CARRIER), 32'(FW_BASE),
                                 32'(FW_STEP)));
`ifdef DIFF_ENC_EN
      quad  = map_poff(diff_q, mode_q);
`else
      quad  = map_poff(s_cur, mode_q);
`endif
      poff  = (sel_q == MOD_PSK) ? {quad, {(PHASE_W-2){1'b0}}} : '0;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sym_d    = sym_q;
      mode_d   = mode_q;
      sel_d    = sel_q;
      strobe_d = 1'b0;
      valid_d  = 1'b0;
      phase_d  = phase_q;
      capture  = 1'b0;
      acc_clr  = 1'b0;
      acc_en   = 1'b0;
`ifdef DIFF_ENC_EN
      diff_d   = diff_q;
      s_new    = sym_eff(sym_in, mode);
      diff_sum = diff_q + s_new;
`endif

      unique case (state_q)
         IDLE: begin
            acc_clr = 1'b1;
`ifdef DIFF_ENC_EN
            diff_d  = 2'd0;
`endif
            if (enable) begin
               capture = 1'b1;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (!enable) begin
               // Abort: drop the partial symbol, restart coherently from 0.
               state_d = IDLE;
               acc_clr = 1'b1;
               cnt_d   = '0;
`ifdef DIFF_ENC_EN
               diff_d  = 2'd0;
`endif
            end else begin
               acc_en  = 1'b1;
               valid_d = 1'b1;
               // acc + fword is the accumulator value being registered now.
               phase_d = acc + fword + poff;
               if (cnt_q == CNT_LAST) begin
                  capture = 1'b1;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
      endcase

      if (capture) begin
         sym_d    = sym_in;
         mode_d   = mode;
         sel_d    = mod_sel;
         strobe_d = 1'b1;
`ifdef DIFF_ENC_EN
         // From IDLE diff_q is already 0, so the first symbol starts the sum.
         if (mod_sel == MOD_PSK) begin
            diff_d = (mode == MODE_2BIT) ? diff_sum : {1'b0, diff_sum[0]};
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         sym_q    <= 2'd0;
         mode_q   <= MODE_1BIT;
         sel_q    <= MOD_FSK;
         strobe_q <= 1'b0;
         valid_q  <= 1'b0;
         phase_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sym_q    <= sym_d;
         mode_q   <= mode_d;
         sel_q    <= sel_d;
         strobe_q <= strobe_d;
         valid_q  <= valid_d;
         phase_q  <= phase_d;
      end
   end

`ifdef DIFF_ENC_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         diff_q <= 2'd0;
      end else begin
         diff_q <= diff_d;
      end
   end
`endif

   nco_phase_acc #(
      .PHASE_W (PHASE_W)
   ) u_acc (
      .clk   (clk),
      .rst   (rst),
      .clr   (acc_clr),
      .en    (acc_en),
      .fword (fword),
      .acc   (acc)
   );

   assign sym_strobe  = strobe_q;
   assign phase_out   = phase_q;
   assign phase_valid = valid_q;

endmodule

// File: tb/tb_symbol_nco_modulator.sv
module tb_symbol_nco_modulator;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        mode;
   logic        mod_sel;
   logic [1:0]  sym_in;
   logic        sym_strobe;
   logic [15:0] phase_out;
   logic        phase_valid;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   symbol_nco_modulator #(
      .PHASE_W    (16),
      .SPS        (4),
      .FW_CARRIER (16'h1000),
      .FW_BASE    (16'h0800),
      .FW_STEP    (16'h0200)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .mode        (mode),
      .mod_sel     (mod_sel),
      .sym_in      (sym_in),
      .sym_strobe  (sym_strobe),
      .phase_out   (phase_out),
      .phase_valid (phase_valid)
   );

   typedef struct {
      logic        en;
      logic        md;
      logic        sel;
      logic [1:0]  sym;
      logic        e_strb;
      logic        e_val;
      logic [15:0] e_ph;
   } vec_t;

   vec_t tbl[11];

   // Outputs are sampled 1 time unit after the active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic en, input logic m, input logic sel, input logic [1:0] s);
      enable  = en;
      mode    = m;
      mod_sel = sel;
      sym_in  = s;
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_out(input string name, input logic s, input logic v,
                            input logic [15:0] p, input logic chk_p);
      check({name, ".strobe"}, 16'(sym_strobe), 16'(s));
      check({name, ".valid"}, 16'(phase_valid), 16'(v));
      if (chk_p) check({name, ".phase"}, phase_out, p);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 2'd0);
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      logic [15:0] e;
      logic [15:0] poff;

      // PSK mode0: sym 1 run, recapture sym 0, enable-low abort and restart.
      tbl[0]  = '{1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 16'h0000};
      tbl[1]  = '{1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 16'h9000};
      tbl[2]  = '{1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 16'hA000};
      tbl[3]  = '{1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 16'hB000};
      tbl[4]  = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 16'hC000};
      tbl[5]  = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 16'h5000};
      tbl[6]  = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 16'h6000};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 16'h0000};
      tbl[8]  = '{1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 16'h0000};
      tbl[9]  = '{1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 16'h9000};
      tbl[10] = '{1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 16'hA000};

      do_reset();
      check_out("reset", 1'b0, 1'b0, 16'h0000, 1'b1);

      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].en, tbl[i].md, tbl[i].sel, tbl[i].sym);
         tick();
         check_out($sformatf("tbl%0d", i), tbl[i].e_strb, tbl[i].e_val, tbl[i].e_ph,
                   tbl[i].e_val);
      end

      // Reset mid-symbol at cnt=2, then restart from cnt=0.
      do_reset();
      drive(1'b1, 1'b0, 1'b1, 2'd1);
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_out("midrst", 1'b0, 1'b0, 16'h0000, 1'b1);
      tick();
      check_out("midrst.cap", 1'b1, 1'b0, 16'h0000, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         tick();
         e = 16'(32'h8000 + k * 32'h1000);
         check_out($sformatf("midrst.s%0d", k), (k == 4), 1'b1, e, 1'b1);
      end

      // FSK 2-bit sym 3; mid-symbol input changes must not take effect.
      do_reset();
      drive(1'b1, 1'b1, 1'b0, 2'd3);
      tick();
      check_out("fsk.cap", 1'b1, 1'b0, 16'h0000, 1'b0);
      tick();
      check_out("fsk.s1", 1'b0, 1'b1, 16'h0E00, 1'b1);
      drive(1'b1, 1'b0, 1'b1, 2'd0);
      tick();
      check_out("fsk.s2", 1'b0, 1'b1, 16'h1C00, 1'b1);
      tick();
      check_out("fsk.s3", 1'b0, 1'b1, 16'h2A00, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 2'd1);
      tick();
      check_out("fsk.s4", 1'b1, 1'b1, 16'h3800, 1'b1);
      tick();
      check_out("fsk.s5", 1'b0, 1'b1, 16'h4200, 1'b1);

      // Wrap: PSK mode0 sym 0, 16 samples ending at 0x0000.
      do_reset();
      drive(1'b1, 1'b0, 1'b1, 2'd0);
      tick();
      check_out("wrap.cap", 1'b1, 1'b0, 16'h0000, 1'b0);
      for (int k = 1; k <= 16; k++) begin
         tick();
         e = 16'(k * 32'h1000);
         check_out($sformatf("wrap.s%0d", k), (k % 4 == 0), 1'b1, e, 1'b1);
      end

      // PSK 2-bit symbols 1,1,2: absolute vs differential offsets.
      do_reset();
      drive(1'b1, 1'b1, 1'b1, 2'd1);
      tick();
      check_out("psk2.cap", 1'b1, 1'b0, 16'h0000, 1'b0);
      for (int k = 1; k <= 9; k++) begin
         sym_in = (k <= 4) ? 2'd1 : 2'd2;
         tick();
`ifdef DIFF_ENC_EN
         poff = (k <= 4) ? 16'h4000 : (k <= 8) ? 16'h8000 : 16'h0000;
`else
         poff = (k <= 4) ? 16'h4000 : (k <= 8) ? 16'h4000 : 16'h8000;
`endif
         e = 16'(k * 32'h1000) + poff;
         check_out($sformatf("psk2.s%0d", k), (k % 4 == 0), 1'b1, e, 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
